// File: rtl/classifier_pkg.sv
// Shared constants and feeder state encoding for the perceptron classifier blocks.
package classifier_pkg;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 200;
  localparam int ADDR_W = 8;

  typedef enum logic [1:0] {
    LOAD  = 2'b00,
    PRIME = 2'b01,
    SERVE = 2'b10
  } feeder_state_e;

endpackage

// File: rtl/sample_feeder_if.sv
// Loader/controller-side bundle for the sample feeder: write port, control strobes and presented sample.
interface sample_feeder_if;
  import classifier_pkg::*;

  logic              wr_en;
  logic [DATA_W-1:0] wr_x1;
  logic [DATA_W-1:0] wr_x2;
  logic [DATA_W-1:0] wr_t;
  logic              load_done;
  logic              reload;
  logic              read_en;
  logic [DATA_W-1:0] x1;
  logic [DATA_W-1:0] x2;
  logic [DATA_W-1:0] t;
  logic              sample_valid;
  logic [ADDR_W-1:0] sample_idx;
  logic              epoch_end;
  logic              full;
  logic [ADDR_W-1:0] count;

  modport master (
    output wr_en, wr_x1, wr_x2, wr_t, load_done, reload, read_en,
    input  x1, x2, t, sample_valid, sample_idx, epoch_end, full, count
  );

  modport slave (
    input  wr_en, wr_x1, wr_x2, wr_t, load_done, reload, read_en,
    output x1, x2, t, sample_valid, sample_idx, epoch_end, full, count
  );

endinterface

// File: rtl/sample_feeder_mem.sv
// DEPTH-entry sample store: synchronous write, synchronous read into a clearable output register.
module sample_feeder_mem
  import classifier_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clr,
  input  logic                i_wr_en,
  input  logic [ADDR_W-1:0]   i_wr_addr,
  input  logic [3*DATA_W-1:0] i_wr_data,
  input  logic                i_rd_en,
  input  logic [ADDR_W-1:0]   i_rd_addr,
  output logic [3*DATA_W-1:0] o_rd_data
);

  logic [3*DATA_W-1:0] r_mem [DEPTH];
  logic [3*DATA_W-1:0] r_rd_data;

  // NOTE: the array has no reset so it maps onto plain storage; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || i_clr)  r_rd_data <= '0;
    else if (i_rd_en)  r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sample_feeder.sv
// Training-sample source: load a set once, then present it sample by sample, wrapping each epoch.
module sample_feeder
  import classifier_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  sample_feeder_if.slave  bus
);

  feeder_state_e       r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_count;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic                r_epoch_end;
  logic [ADDR_W-1:0]   w_rd_next;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic                w_full;
  logic                w_wr_accept;
  logic                w_rd_en;
  logic [3*DATA_W-1:0] w_rd_data;

  assign w_full    = (r_count == ADDR_W'(DEPTH));
  assign w_rd_next = (r_rd_ptr == r_count - 1'b1) ? '0 : r_rd_ptr + 1'b1;

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_accept = 1'b0;
    w_rd_en     = 1'b0;
    w_rd_addr   = '0;
    case (r_state)
      LOAD: begin
        w_wr_accept = bus.wr_en && !w_full;
        // A write in the same cycle as load_done counts towards a non-empty set.
        if (bus.load_done && (r_count != '0 || w_wr_accept)) w_state_nxt = PRIME;
      end
      PRIME: begin
        w_rd_en     = 1'b1;
        w_state_nxt = SERVE;
      end
      SERVE: begin
        w_rd_en   = bus.read_en;
        w_rd_addr = w_rd_next;
      end
      default: w_state_nxt = LOAD;
    endcase
    if (bus.reload) begin
      w_state_nxt = LOAD;
      w_wr_accept = 1'b0;
      w_rd_en     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= LOAD;
      r_count     <= '0;
      r_rd_ptr    <= '0;
      r_epoch_end <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_epoch_end <= 1'b0;
      if (bus.reload) begin
        r_count  <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_wr_accept) r_count <= r_count + 1'b1;
        if (w_rd_en) begin
          r_rd_ptr    <= w_rd_addr;
          r_epoch_end <= (r_state == SERVE) && (w_rd_addr == '0);
        end
      end
    end
  end

  sample_feeder_mem u_mem (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (bus.reload),
    .i_wr_en   (w_wr_accept),
    .i_wr_addr (r_count),
    .i_wr_data ({bus.wr_x1, bus.wr_x2, bus.wr_t}),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  assign bus.x1           = w_rd_data[3*DATA_W-1:2*DATA_W];
  assign bus.x2           = w_rd_data[2*DATA_W-1:DATA_W];
  assign bus.t            = w_rd_data[DATA_W-1:0];
  assign bus.sample_valid = (r_state == SERVE);
  assign bus.sample_idx   = r_rd_ptr;
  assign bus.epoch_end    = r_epoch_end;
  assign bus.full         = w_full;
  assign bus.count        = r_count;

endmodule

// File: tb/tb_sample_feeder.sv
// Self-checking bench for sample_feeder: table-driven load/serve plus scoreboarded read sequences.
module tb_sample_feeder;
  import classifier_pkg::*;

  typedef struct {
    logic [7:0] x1;
    logic [7:0] x2;
    logic [7:0] t;
    int         exp_idx;
    logic       exp_epoch;
  } vec_t;

  typedef struct {
    logic [7:0] x1;
    logic [7:0] x2;
    logic [7:0] t;
    int         idx;
    logic       epoch;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [7:0] m_x1 [DEPTH];
  logic [7:0] m_x2 [DEPTH];
  logic [7:0] m_t  [DEPTH];
  int         m_cnt;
  int         m_ptr;
  exp_t       sb_q [$];
  vec_t       vec  [3];

  sample_feeder_if bus ();

  sample_feeder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_en     = 1'b0;
    bus.wr_x1     = '0;
    bus.wr_x2     = '0;
    bus.wr_t      = '0;
    bus.load_done = 1'b0;
    bus.reload    = 1'b0;
    bus.read_en   = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_x1"},    32'(bus.x1), 0);
    check({tag, "_x2"},    32'(bus.x2), 0);
    check({tag, "_t"},     32'(bus.t), 0);
    check({tag, "_valid"}, 32'(bus.sample_valid), 0);
    check({tag, "_idx"},   32'(bus.sample_idx), 0);
    check({tag, "_epoch"}, 32'(bus.epoch_end), 0);
    check({tag, "_full"},  32'(bus.full), 0);
    check({tag, "_count"}, 32'(bus.count), 0);
  endtask

  task automatic write_sample(input logic [7:0] x1, input logic [7:0] x2, input logic [7:0] t,
                              input logic with_done);
    bus.wr_en     = 1'b1;
    bus.wr_x1     = x1;
    bus.wr_x2     = x2;
    bus.wr_t      = t;
    bus.load_done = with_done;
    if (m_cnt < DEPTH) begin
      m_x1[m_cnt] = x1;
      m_x2[m_cnt] = x2;
      m_t[m_cnt]  = t;
      m_cnt++;
    end
    tick();
    idle_inputs();
  endtask

  task automatic check_present(input string tag);
    check({tag, "_valid"}, 32'(bus.sample_valid), 1);
    check({tag, "_x1"},    32'(bus.x1), 32'(m_x1[m_ptr]));
    check({tag, "_x2"},    32'(bus.x2), 32'(m_x2[m_ptr]));
    check({tag, "_t"},     32'(bus.t), 32'(m_t[m_ptr]));
    check({tag, "_idx"},   32'(bus.sample_idx), 32'(m_ptr));
  endtask

  task automatic push_next();
    exp_t e;
    int   nxt;
    nxt     = (m_ptr == m_cnt - 1) ? 0 : m_ptr + 1;
    e.x1    = m_x1[nxt];
    e.x2    = m_x2[nxt];
    e.t     = m_t[nxt];
    e.idx   = nxt;
    e.epoch = (nxt == 0);
    sb_q.push_back(e);
    m_ptr = nxt;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_x1"},    32'(bus.x1), 32'(e.x1));
    check({tag, "_x2"},    32'(bus.x2), 32'(e.x2));
    check({tag, "_t"},     32'(bus.t), 32'(e.t));
    check({tag, "_idx"},   32'(bus.sample_idx), 32'(e.idx));
    check({tag, "_epoch"}, 32'(bus.epoch_end), 32'(e.epoch));
  endtask

  // read_en held high for n consecutive cycles, one scoreboard entry per edge
  task automatic read_burst(input string tag, input int n);
    bus.read_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      push_next();
      tick();
      if (i == n - 1) bus.read_en = 1'b0;
      pop_check(tag);
    end
  endtask

  task automatic start_serving();
    bus.load_done = 1'b1;
    tick();
    idle_inputs();
    check("prime_valid", 32'(bus.sample_valid), 0);
    tick();
    m_ptr = 0;
  endtask

  task automatic reset_model();
    m_cnt = 0;
    m_ptr = 0;
    sb_q.delete();
  endtask

  initial begin
    idle_inputs();
    reset_model();
    tick();
    tick();
    rst = 1'b0;
    check_cleared("reset");

    // Basic three-sample set and one full epoch of reads spaced four cycles apart
    vec[0].x1 = 8'd5;  vec[0].x2 = 8'hFD; vec[0].t = 8'd1;  vec[0].exp_idx = 1; vec[0].exp_epoch = 1'b0;
    vec[1].x1 = 8'd2;  vec[1].x2 = 8'd7;  vec[1].t = 8'hFF; vec[1].exp_idx = 2; vec[1].exp_epoch = 1'b0;
    vec[2].x1 = 8'hFC; vec[2].x2 = 8'd1;  vec[2].t = 8'd1;  vec[2].exp_idx = 0; vec[2].exp_epoch = 1'b1;
    for (int i = 0; i < 3; i++) write_sample(vec[i].x1, vec[i].x2, vec[i].t, 1'b0);
    check("load3_count", 32'(bus.count), 3);
    check("load3_full", 32'(bus.full), 0);
    start_serving();
    check_present("first");
    check("first_x1_lit", 32'(bus.x1), 5);
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      repeat (3) tick();
      check("hold_idx", 32'(bus.sample_idx), 32'(m_ptr));
      e.x1    = vec[vec[i].exp_idx].x1;
      e.x2    = vec[vec[i].exp_idx].x2;
      e.t     = vec[vec[i].exp_idx].t;
      e.idx   = vec[i].exp_idx;
      e.epoch = vec[i].exp_epoch;
      sb_q.push_back(e);
      m_ptr = vec[i].exp_idx;
      bus.read_en = 1'b1;
      tick();
      bus.read_en = 1'b0;
      pop_check("step");
    end
    tick();
    check("epoch_one_cycle", 32'(bus.epoch_end), 0);

    // reload together with read_en at idx 1
    read_burst("to_idx1", 1);
    bus.reload  = 1'b1;
    bus.read_en = 1'b1;
    tick();
    idle_inputs();
    reset_model();
    check_cleared("reload");

    // load_done on an empty set is ignored; read_en in LOAD changes nothing
    bus.load_done = 1'b1;
    tick();
    idle_inputs();
    tick();
    check("empty_done_valid", 32'(bus.sample_valid), 0);
    bus.read_en = 1'b1;
    tick();
    idle_inputs();
    check_cleared("read_in_load");

    // wr_en and load_done in the same cycle: single-sample set
    write_sample(8'd9, 8'hF7, 8'hFF, 1'b1);
    check("single_count", 32'(bus.count), 1);
    check("single_prime_valid", 32'(bus.sample_valid), 0);
    tick();
    m_ptr = 0;
    check_present("single");
    read_burst("single_rd", 2);

    // rst together with read_en at idx 1
    bus.reload = 1'b1;
    tick();
    idle_inputs();
    reset_model();
    write_sample(8'd11, 8'd12, 8'd1, 1'b0);
    write_sample(8'd21, 8'd22, 8'hFF, 1'b0);
    start_serving();
    read_burst("rst_idx1", 1);
    rst         = 1'b1;
    bus.read_en = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    reset_model();
    check_cleared("rst_mid");

    // Full-depth load, overflow write ignored, back-to-back reads through a full epoch
    for (int i = 0; i < DEPTH + 1; i++) begin
      logic [7:0] v;
      v = 8'(i);
      write_sample(v, ~v, v[0] ? 8'hFF : 8'd1, 1'b0);
      if (i == DEPTH - 2) check("full_before_last", 32'(bus.full), 0);
      if (i == DEPTH - 1) check("full_at_depth", 32'(bus.full), 1);
    end
    check("overflow_count", 32'(bus.count), DEPTH);
    check("overflow_full", 32'(bus.full), 1);
    start_serving();
    check_present("deep_first");
    read_burst("b2b", 2);
    check("b2b_idx2", 32'(bus.sample_idx), 2);
    read_burst("epoch", DEPTH - 2);
    check_present("wrap_sample0");
    tick();
    check("deep_epoch_clear", 32'(bus.epoch_end), 0);
    check("sb_drained", 32'(sb_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sample_feeder.md
Name: sample_feeder

Overview:
- Upstream training-data source for the perceptron classifier controller/datapath.
- Holds up to DEPTH training samples (x1, x2, target), written once by the testbench or loader.
- Presents the current sample on registered outputs so the datapath can capture it in the same cycle the controller pulses read_en.
- Advances on each read_en and wraps at the end of the loaded set, so the controller can run repeated epochs without reloading.

Parameters:
- DATA_W, 8, width of x1, x2 and t (two's complement).
- DEPTH, 200, maximum sample count; equals the controller's per-epoch count.
- ADDR_W, 8, pointer width; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write one sample in LOAD state.
- wr_x1  in  DATA_W  sample feature 1 to write.
- wr_x2  in  DATA_W  sample feature 2 to write.
- wr_t  in  DATA_W  sample target to write (+1/-1).
- load_done  in  1  end of loading; request transition to serving.
- reload  in  1  abandon serving and return to LOAD with count cleared.
- read_en  in  1  consume current sample and advance (controller ReadEn).
- x1  out  DATA_W  current sample feature 1.
- x2  out  DATA_W  current sample feature 2.
- t  out  DATA_W  current sample target.
- sample_valid  out  1  x1/x2/t hold a valid sample (SERVE state).
- sample_idx  out  ADDR_W  index of the sample currently presented.
- epoch_end  out  1  one-cycle pulse when the pointer wraps to 0.
- full  out  1  count == DEPTH.
- count  out  ADDR_W  number of samples loaded.

Behaviour:
- Interface fixed: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state = LOAD; wr_ptr, rd_ptr, count, sample_idx = 0; x1/x2/t = 0; sample_valid, epoch_end, full = 0. Memory contents are not cleared.
- Storage: DEPTH x (3*DATA_W) register array; write is synchronous, read is synchronous into the output registers.
- FSM states: LOAD, PRIME, SERVE.
- LOAD:
  - wr_en with count < DEPTH writes mem[count] and increments count.
  - wr_en while full is ignored; count stays at DEPTH.
  - load_done with count > 0 goes to PRIME. If wr_en is asserted in the same cycle, that write is accepted first and counted.
  - load_done with count == 0 is ignored; the FSM stays in LOAD.
  - read_en is ignored.
- PRIME (exactly 1 cycle):
  - Loads x1/x2/t from mem[0]; rd_ptr = 0.
  - Goes to SERVE; sample_valid = 1 from the first SERVE cycle.
- SERVE:
  - Outputs hold steady until read_en.
  - On a read_en cycle the datapath captures the current outputs. At the next edge, outputs take mem[next]. next = rd_ptr+1, or 0 when rd_ptr == count-1. rd_ptr and sample_idx update to next.
  - Wrap: on the edge where next == 0, epoch_end = 1 for one cycle.
  - Back-to-back read_en on consecutive cycles is legal and advances once per cycle.
  - count == 1: every read_en re-presents sample 0 and pulses epoch_end.
  - wr_en and load_done are ignored.
- reload, accepted in any state: next cycle state = LOAD, count = 0, rd_ptr = 0, sample_valid = 0, outputs = 0. reload has priority over read_en and load_done in the same cycle.
- rst mid-operation has the same effect as reload plus all outputs at reset values; it overrides every other input.
- Latency: read_en to new sample on outputs = 1 cycle; load_done to sample_valid = 2 cycles.
- full is combinational from count.

Decomposition:
- Shared package (classifier_pkg): DATA_W, DEPTH, ADDR_W constants; feeder state encoding (LOAD=2'b00, PRIME=2'b01, SERVE=2'b10).
- One natural sub-module: sample_mem, a DEPTH x 3*DATA_W synchronous-write/synchronous-read array. The pointer/FSM logic stays in sample_feeder.

Test Plan:
- Load 3 samples (5,-3,+1),(2,7,-1),(-4,1,+1), pulse load_done -> count=3; 2 cycles later sample_valid=1, x1=5, x2=-3, t=1, sample_idx=0.
- Issue read_en 3 times, 4 cycles apart -> outputs step to (2,7,-1), then (-4,1,+1), then (5,-3,+1). epoch_end pulses exactly once, the cycle sample_idx returns to 0.
- Write 201 samples with DEPTH=200 -> full=1 after the 200th, count=200; the 201st is ignored; after 200 read_en, epoch_end=1 and the sample 0 values reappear.
- load_done with count=0 -> state stays LOAD, sample_valid=0. Then wr_en+load_done in the same cycle -> count=1, serving begins with that sample.
- read_en asserted on 2 consecutive cycles from idx 0 -> idx 1, then 2 on successive edges. read_en in LOAD -> no output change.
- reload (and separately rst) asserted together with read_en in SERVE at idx 1 -> next cycle state LOAD, count=0, sample_valid=0, x1=x2=t=0.
